// File: rtl/axi_burst_wr_ctrl_pkg.sv
// Shared DDR write-path definitions.
// Holds the default bus geometry used by the burst write controller, its
// interface and its data FIFO, plus the one-hot controller state encoding.
package p_ddr;

    localparam int unsigned DDR_DATA_W     = 256;
    localparam int unsigned DDR_ADDR_W     = 28;
    localparam int unsigned DDR_LEN_W      = 4;
    localparam int unsigned DDR_FIFO_DEPTH = 16;

    // One-hot so each state decode is a single flop bit.
    typedef enum logic [3:0] {
        StIdle = 4'b0001,
        StAddr = 4'b0010,
        StData = 4'b0100,
        StDone = 4'b1000
    } wr_state_e;

endpackage

// File: rtl/axi_burst_wr_ctrl_if.sv
// Bundle of the user-side command/data ports and the AXI AW/W channels of the
// burst write controller.
//   master : controller view (drives AXI AW/W, command/data ready and status)
//   slave  : environment view (user logic plus AXI slave)
interface axi_burst_wr_ctrl_if
    import p_ddr::*;
#(
    parameter int unsigned DATA_W = DDR_DATA_W,
    parameter int unsigned ADDR_W = DDR_ADDR_W,
    parameter int unsigned LEN_W  = DDR_LEN_W
) ();

    localparam int unsigned STRB_W = DATA_W / 8;

    // User command
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [LEN_W-1:0]  wr_len;
    logic              wr_ready;
    // User data push
    logic [DATA_W-1:0] wr_data;
    logic [STRB_W-1:0] wr_be;
    logic              wr_data_valid;
    logic              wr_data_ready;
    // Status
    logic              wr_busy;
    logic              wr_done;
    // AXI write address channel
    logic [ADDR_W-1:0] axi_awaddr;
    logic [LEN_W-1:0]  axi_awlen;
    logic              axi_awvalid;
    logic              axi_awready;
    // AXI write data channel
    logic [DATA_W-1:0] axi_wdata;
    logic [STRB_W-1:0] axi_wstrb;
    logic              axi_wvalid;
    logic              axi_wlast;
    logic              axi_wready;

    modport master (
        input  wr_req, wr_addr, wr_len, wr_data, wr_be, wr_data_valid,
        input  axi_awready, axi_wready,
        output wr_ready, wr_data_ready, wr_busy, wr_done,
        output axi_awaddr, axi_awlen, axi_awvalid,
        output axi_wdata, axi_wstrb, axi_wvalid, axi_wlast
    );

    modport slave (
        output wr_req, wr_addr, wr_len, wr_data, wr_be, wr_data_valid,
        output axi_awready, axi_wready,
        input  wr_ready, wr_data_ready, wr_busy, wr_done,
        input  axi_awaddr, axi_awlen, axi_awvalid,
        input  axi_wdata, axi_wstrb, axi_wvalid, axi_wlast
    );

endinterface

// File: rtl/axi_burst_wr_ctrl_fifo.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO.
// The head entry is visible on dout_o whenever empty_o is low; pop_i advances.
// Ports:
//   clk_100M, rstn     : clock, synchronous active-low reset (flushes pointers)
//   push_i, din_i      : write; ignored while full_o
//   pop_i, dout_o      : read/advance; ignored while empty_o
//   full_o, empty_o    : occupancy flags
//   count_o            : registered occupancy, 0..DEPTH
module sync_fifo_fwft #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_100M,
    input  logic                     rstn,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             push_en;
    logic             pop_en;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    always_ff @(posedge clk_100M) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            unique case ({push_en, pop_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk_100M) begin
        if (push_en) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/axi_burst_wr_ctrl.sv
// axi_burst_wr_ctrl: turns a user burst command plus a pushed data stream into
// one AXI write address transfer followed by wr_len+1 write data beats.
// Data may be pushed at any time (also ahead of the command) into a FWFT FIFO;
// the W channel drains it only after the AW handshake.
// Ports:
//   clk_100M, rstn : clock, synchronous active-low reset
//   init_done      : DDR calibration complete, gates command acceptance only
//   bus (master)   : user command/data/status and AXI AW/W channels
module axi_burst_wr_ctrl
    import p_ddr::*;
#(
    parameter int unsigned DATA_W     = DDR_DATA_W,
    parameter int unsigned ADDR_W     = DDR_ADDR_W,
    parameter int unsigned LEN_W      = DDR_LEN_W,
    parameter int unsigned FIFO_DEPTH = DDR_FIFO_DEPTH
) (
    input logic                 clk_100M,
    input logic                 rstn,
    input logic                 init_done,
    axi_burst_wr_ctrl_if.master bus
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned FIFO_W = DATA_W + STRB_W;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    wr_state_e         state_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [LEN_W-1:0]  awlen_q;
    logic              awvalid_q;
    logic [LEN_W-1:0]  beat_cnt_q;
    logic              busy_q;
    logic              done_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic [FIFO_W-1:0] fifo_head;
    logic [CNT_W-1:0]  unused_fifo_count;

    logic              cmd_ready;
    logic              wvalid;
    logic              wlast;
    logic              beat;

    assign cmd_ready = (state_q == StIdle) & init_done;
    assign wvalid    = (state_q == StData) & ~fifo_empty;
    assign wlast     = wvalid & (beat_cnt_q == awlen_q);
    assign beat      = wvalid & bus.axi_wready;

    assign fifo_push = bus.wr_data_valid & ~fifo_full;
    assign fifo_pop  = beat;

    sync_fifo_fwft #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_100M (clk_100M),
        .rstn     (rstn),
        .push_i   (fifo_push),
        .din_i    ({bus.wr_be, bus.wr_data}),
        .pop_i    (fifo_pop),
        .dout_o   (fifo_head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .count_o  (unused_fifo_count)
    );

    always_ff @(posedge clk_100M) begin
        if (!rstn) begin
            state_q    <= StIdle;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            awvalid_q  <= 1'b0;
            beat_cnt_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.wr_req && cmd_ready) begin
                        awaddr_q   <= bus.wr_addr;
                        awlen_q    <= bus.wr_len;
                        awvalid_q  <= 1'b1;
                        beat_cnt_q <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= StAddr;
                    end
                end
                StAddr: begin
                    if (awvalid_q && bus.axi_awready) begin
                        awvalid_q <= 1'b0;
                        state_q   <= StData;
                    end
                end
                StData: begin
                    if (beat) begin
                        if (wlast) begin
                            // Counter stops at awlen, so it never wraps.
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + LEN_W'(1);
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.wr_ready      = cmd_ready;
    assign bus.wr_data_ready = ~fifo_full;
    assign bus.wr_busy       = busy_q;
    assign bus.wr_done       = done_q;
    assign bus.axi_awaddr    = awaddr_q;
    assign bus.axi_awlen     = awlen_q;
    assign bus.axi_awvalid   = awvalid_q;
    assign bus.axi_wvalid    = wvalid;
    assign bus.axi_wlast     = wlast;
    assign bus.axi_wdata     = fifo_head[DATA_W-1:0];
    assign bus.axi_wstrb     = fifo_head[FIFO_W-1:DATA_W];

endmodule

// File: tb/tb_axi_burst_wr_ctrl.sv
// Testbench for axi_burst_wr_ctrl: a table of burst descriptors with
// hand-computed expectations, plus directed sequences for FIFO full,
// simultaneous push/pop, init_done gating and reset in the middle of a burst.
module tb_axi_burst_wr_ctrl;
    import p_ddr::*;

    localparam int unsigned DATA_W     = 256;
    localparam int unsigned ADDR_W     = 28;
    localparam int unsigned LEN_W      = 4;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned STRB_W     = DATA_W / 8;

    logic clk_100M = 1'b0;
    logic rstn;
    logic init_done;

    always #5 clk_100M = ~clk_100M;

    axi_burst_wr_ctrl_if #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) bus ();

    axi_burst_wr_ctrl #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .LEN_W      (LEN_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_100M  (clk_100M),
        .rstn      (rstn),
        .init_done (init_done),
        .bus       (bus)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        int                prefill;
        int                aw_delay;
        int                gap;
        logic [15:0]       wready_pat;
        logic [STRB_W-1:0] be_b2;
        logic [15:0]       tag;
        int                exp_beats;
        int                exp_aw_cycles;
        bit                exp_gaps;
    } burst_t;

    burst_t tbl[6];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] beat_data(input logic [15:0] tag, input int i);
        return {8{tag, 16'(i)}};
    endfunction

    function automatic logic [STRB_W-1:0] beat_be(input burst_t v, input int i);
        return (i == 1) ? v.be_b2 : ~STRB_W'(i);
    endfunction

    task automatic idle_inputs();
        bus.wr_req        = 1'b0;
        bus.wr_addr       = '0;
        bus.wr_len        = '0;
        bus.wr_data       = '0;
        bus.wr_be         = '0;
        bus.wr_data_valid = 1'b0;
        bus.axi_awready   = 1'b0;
        bus.axi_wready    = 1'b0;
    endtask

    // Inputs change and outputs are sampled at the falling edge; the handshakes
    // evaluated here fire on the following rising edge.
    task automatic run_burst(input burst_t v);
        int pushed = 0, beats = 0, aw_cycles = 0, wlasts = 0, gaps = 0;
        int last_cyc = -10, done_cnt = 0, done_cyc = -10;
        bit req_sent = 0, aw_done = 0, early_w = 0, unstable = 0, aw_bad = 0, busy_bad = 0;
        bit prev_stall = 0, push_now;
        logic ready_end = 1'b0, done_end = 1'b1;
        logic [DATA_W-1:0] prev_d = '0;
        logic [STRB_W-1:0] prev_s = '0;
        logic prev_l = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk_100M);
            if (done_cnt > 0 && cyc == done_cyc + 1) begin
                ready_end = bus.wr_ready;
                done_end  = bus.wr_done;
                break;
            end
            if (bus.wr_done) begin
                done_cnt++;
                done_cyc = cyc;
                if (bus.wr_busy) busy_bad = 1;
            end
            if (bus.axi_awvalid) begin
                aw_cycles++;
                if (bus.axi_awaddr !== v.addr || bus.axi_awlen !== v.len) aw_bad = 1;
            end
            if (bus.axi_wvalid && !aw_done) early_w = 1;
            if (prev_stall && (!bus.axi_wvalid || bus.axi_wdata !== prev_d ||
                               bus.axi_wstrb !== prev_s || bus.axi_wlast !== prev_l))
                unstable = 1;
            if (aw_done && bus.wr_busy && !bus.axi_wvalid) gaps++;
            if (req_sent && done_cnt == 0 && !bus.wr_busy) busy_bad = 1;

            bus.wr_req = 1'b0;
            if (!req_sent && pushed >= v.prefill) begin
                bus.wr_req  = 1'b1;
                bus.wr_addr = v.addr;
                bus.wr_len  = v.len;
                if (bus.wr_ready) req_sent = 1;
            end
            bus.axi_awready = bus.axi_awvalid && (aw_cycles > v.aw_delay);
            if (bus.axi_awready) aw_done = 1;
            bus.axi_wready = v.wready_pat[cyc % 16];
            push_now = (pushed < v.exp_beats) &&
                       ((pushed < v.prefill) || (cyc % (v.gap + 1) == 0));
            bus.wr_data_valid = push_now;
            bus.wr_data       = beat_data(v.tag, pushed);
            bus.wr_be         = beat_be(v, pushed);
            if (push_now && bus.wr_data_ready) pushed++;

            if (bus.axi_wvalid && bus.axi_wready) begin
                check($sformatf("wdata[%0d]", beats), bus.axi_wdata, beat_data(v.tag, beats));
                check($sformatf("wstrb[%0d]", beats), DATA_W'(bus.axi_wstrb),
                      DATA_W'(beat_be(v, beats)));
                check($sformatf("wlast[%0d]", beats), DATA_W'(bus.axi_wlast),
                      DATA_W'(beats == int'(v.len)));
                if (bus.axi_wlast) begin
                    wlasts++;
                    last_cyc = cyc;
                end
                beats++;
            end
            prev_stall = bus.axi_wvalid && !bus.axi_wready;
            prev_d     = bus.axi_wdata;
            prev_s     = bus.axi_wstrb;
            prev_l     = bus.axi_wlast;
        end
        idle_inputs();
        check("aw_cycles",   DATA_W'(aw_cycles), DATA_W'(v.exp_aw_cycles));
        check("aw_payload",  DATA_W'(aw_bad), '0);
        check("beat_count",  DATA_W'(beats), DATA_W'(v.exp_beats));
        check("wlast_count", DATA_W'(wlasts), DATA_W'(1));
        check("done_count",  DATA_W'(done_cnt), DATA_W'(1));
        check("done_timing", DATA_W'(done_cyc - last_cyc), DATA_W'(1));
        check("early_wvalid", DATA_W'(early_w), '0);
        check("stall_stable", DATA_W'(unstable), '0);
        check("busy_window", DATA_W'(busy_bad), '0);
        check("wvalid_gaps", DATA_W'(gaps > 0), DATA_W'(v.exp_gaps));
        check("ready_after", DATA_W'(ready_end), DATA_W'(1));
        check("done_pulse",  DATA_W'(done_end), '0);
    endtask

    task automatic check_reset_outputs(input string tag, input logic exp_wr_ready);
        check({tag, "_awaddr"},  DATA_W'(bus.axi_awaddr), '0);
        check({tag, "_awlen"},   DATA_W'(bus.axi_awlen), '0);
        check({tag, "_awvalid"}, DATA_W'(bus.axi_awvalid), '0);
        check({tag, "_wvalid"},  DATA_W'(bus.axi_wvalid), '0);
        check({tag, "_wlast"},   DATA_W'(bus.axi_wlast), '0);
        check({tag, "_busy"},    DATA_W'(bus.wr_busy), '0);
        check({tag, "_done"},    DATA_W'(bus.wr_done), '0);
        check({tag, "_dready"},  DATA_W'(bus.wr_data_ready), DATA_W'(1));
        check({tag, "_count"},   DATA_W'(dut.u_fifo.count_o), '0);
        check({tag, "_wready"},  DATA_W'(bus.wr_ready), DATA_W'(exp_wr_ready));
    endtask

    initial begin
        int  nb;
        bit  seen_done;

        tbl[0] = '{addr: 28'h0000100, len: 4'd3, prefill: 4, aw_delay: 0, gap: 0,
                   wready_pat: 16'hFFFF, be_b2: 32'hFFFF_FFFF, tag: 16'hA000,
                   exp_beats: 4, exp_aw_cycles: 1, exp_gaps: 1'b0};
        tbl[1] = '{addr: 28'h0ABCDE0, len: 4'd7, prefill: 8, aw_delay: 5, gap: 0,
                   wready_pat: 16'hFFFF, be_b2: 32'h1234_5678, tag: 16'hB000,
                   exp_beats: 8, exp_aw_cycles: 6, exp_gaps: 1'b0};
        tbl[2] = '{addr: 28'h0002000, len: 4'd15, prefill: 0, aw_delay: 0, gap: 2,
                   wready_pat: 16'hFFFF, be_b2: 32'hF0F0_F0F0, tag: 16'hC000,
                   exp_beats: 16, exp_aw_cycles: 1, exp_gaps: 1'b1};
        tbl[3] = '{addr: 28'h0FFFFC0, len: 4'd5, prefill: 6, aw_delay: 0, gap: 0,
                   wready_pat: 16'h69C5, be_b2: 32'h0000_000F, tag: 16'hD000,
                   exp_beats: 6, exp_aw_cycles: 1, exp_gaps: 1'b0};
        tbl[4] = '{addr: 28'hFFFFFFF, len: 4'd0, prefill: 1, aw_delay: 1, gap: 0,
                   wready_pat: 16'hFFFE, be_b2: 32'hFFFF_FFFF, tag: 16'h1000,
                   exp_beats: 1, exp_aw_cycles: 2, exp_gaps: 1'b0};
        tbl[5] = '{addr: 28'h5A5A5A0, len: 4'd15, prefill: 16, aw_delay: 2, gap: 0,
                   wready_pat: 16'h5555, be_b2: 32'h8000_0001, tag: 16'hE000,
                   exp_beats: 16, exp_aw_cycles: 3, exp_gaps: 1'b0};

        // Reset state, with calibration still pending.
        rstn      = 1'b0;
        init_done = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk_100M);
        rstn = 1'b1;
        @(negedge clk_100M);
        check_reset_outputs("rst", 1'b0);

        // Request before calibration completes is ignored.
        bus.wr_req  = 1'b1;
        bus.wr_addr = 28'h0000123;
        bus.wr_len  = 4'd2;
        repeat (3) @(negedge clk_100M);
        check("nocal_awvalid", DATA_W'(bus.axi_awvalid), '0);
        check("nocal_busy", DATA_W'(bus.wr_busy), '0);
        bus.wr_req = 1'b0;
        init_done  = 1'b1;
        #1;
        check("cal_wr_ready", DATA_W'(bus.wr_ready), DATA_W'(1));

        for (int i = 0; i < 6; i++) run_burst(tbl[i]);

        // Fill to full with no command pending.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk_100M);
            bus.wr_data_valid = 1'b1;
            bus.wr_data       = beat_data(16'h5000, i);
            bus.wr_be         = '1;
        end
        @(negedge clk_100M);
        check("full_dready", DATA_W'(bus.wr_data_ready), '0);
        check("full_count", DATA_W'(dut.u_fifo.count_o), DATA_W'(16));
        @(negedge clk_100M);
        check("full_blocked", DATA_W'(dut.u_fifo.count_o), DATA_W'(16));
        bus.wr_data_valid = 1'b0;
        bus.wr_req        = 1'b1;
        bus.wr_addr       = 28'h0003000;
        bus.wr_len        = 4'd15;
        check("full_wr_ready", DATA_W'(bus.wr_ready), DATA_W'(1));
        @(negedge clk_100M);
        bus.wr_req      = 1'b0;
        check("c_awvalid", DATA_W'(bus.axi_awvalid), DATA_W'(1));
        bus.axi_awready = 1'b1;
        init_done       = 1'b0;  // calibration drops mid-burst
        @(negedge clk_100M);
        bus.axi_awready = 1'b0;
        check("c_wvalid", DATA_W'(bus.axi_wvalid), DATA_W'(1));
        check("c_wdata0", bus.axi_wdata, beat_data(16'h5000, 0));
        bus.axi_wready = 1'b1;
        @(negedge clk_100M);
        check("pop_count", DATA_W'(dut.u_fifo.count_o), DATA_W'(15));
        check("pop_dready", DATA_W'(bus.wr_data_ready), DATA_W'(1));
        bus.wr_data_valid = 1'b1;
        bus.wr_data       = beat_data(16'h5000, 16);
        @(negedge clk_100M);
        check("pushpop_count", DATA_W'(dut.u_fifo.count_o), DATA_W'(15));
        bus.wr_data_valid = 1'b0;
        nb        = 2;
        seen_done = 0;
        for (int k = 0; k < 40 && !seen_done; k++) begin
            if (bus.axi_wvalid) nb++;
            @(negedge clk_100M);
            if (bus.wr_done) seen_done = 1;
        end
        check("c_done", DATA_W'(seen_done), DATA_W'(1));
        check("c_beats", DATA_W'(nb), DATA_W'(16));
        check("c_leftover", DATA_W'(dut.u_fifo.count_o), DATA_W'(1));
        check("c_wr_ready_nocal", DATA_W'(bus.wr_ready), '0);
        bus.axi_wready = 1'b0;
        init_done      = 1'b1;

        // Reset pulse while beat 2 of 8 is on the bus.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_100M);
            bus.wr_data_valid = 1'b1;
            bus.wr_data       = beat_data(16'h6000, i);
            bus.wr_be         = '1;
        end
        @(negedge clk_100M);
        bus.wr_data_valid = 1'b0;
        bus.wr_req        = 1'b1;
        bus.wr_addr       = 28'h0004000;
        bus.wr_len        = 4'd7;
        @(negedge clk_100M);
        bus.wr_req      = 1'b0;
        bus.axi_awready = 1'b1;
        @(negedge clk_100M);
        bus.axi_awready = 1'b0;
        bus.axi_wready  = 1'b1;
        @(negedge clk_100M);
        check("d_beat2_valid", DATA_W'(bus.axi_wvalid), DATA_W'(1));
        check("d_beat2_wlast", DATA_W'(bus.axi_wlast), '0);
        rstn = 1'b0;
        @(negedge clk_100M);
        check_reset_outputs("midrst", 1'b1);
        rstn = 1'b1;
        idle_inputs();
        run_burst(tbl[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axi_burst_wr_ctrl.md
AXI_BURST_WR_CTRL -- requirements
Module: axi_burst_wr_ctrl

Interface
REQ-001 Parameter DATA_W, 256: AXI/user data width in bits; must be a multiple of 8.
REQ-002 Parameter ADDR_W, 28: AXI/user address width.
REQ-003 Parameter LEN_W, 4: burst length field width; a burst is wr_len+1 beats, max 2^LEN_W.
REQ-004 Parameter FIFO_DEPTH, 16: write-data FIFO entries; must be a power of 2 and at least 2^LEN_W.
REQ-005 Derived STRB_W = DATA_W/8.
REQ-006 Reset rstn, synchronous, active-low; clock clk_100M.
REQ-007 Port clk_100M, in, 1: sole clock.
REQ-008 Port rstn, in, 1: synchronous active-low reset.
REQ-009 Port init_done, in, 1: DDR calibration complete; gates command acceptance only.
REQ-010 Port wr_req, in, 1: level burst request; qualified by wr_ready.
REQ-011 Port wr_addr, in, ADDR_W: burst start address.
REQ-012 Port wr_len, in, LEN_W: beats minus one.
REQ-013 Port wr_ready, out, 1: command acceptable; equals (state==IDLE) & init_done.
REQ-014 Port wr_data, in, DATA_W, and wr_be, in, STRB_W: beat payload and byte enables.
REQ-015 Port wr_data_valid, in, 1, and wr_data_ready, out, 1: data push handshake; wr_data_ready = FIFO not full.
REQ-016 Port wr_busy, out, 1: high from command accept until the cycle wr_done is asserted.
REQ-017 Port wr_done, out, 1: one-cycle pulse after the last beat is accepted.
REQ-018 Ports axi_awaddr (ADDR_W), axi_awlen (LEN_W), axi_awvalid (1), out; axi_awready (1), in.
REQ-019 Ports axi_wdata (DATA_W), axi_wstrb (STRB_W), axi_wvalid (1), axi_wlast (1), out; axi_wready (1), in.

Function
REQ-020 States: IDLE, ADDR, DATA, DONE, one-hot encoded.
REQ-021 IDLE->ADDR on wr_req & wr_ready; the same edge latches wr_addr into axi_awaddr and wr_len into axi_awlen, clears beat counter, and sets wr_busy.
REQ-022 ADDR: axi_awvalid=1; awvalid and its payload held stable until axi_awvalid & axi_awready, then ADDR->DATA and awvalid cleared on that edge.
REQ-023 DATA: axi_wvalid = FIFO not empty; axi_wdata/axi_wstrb = FIFO head (first-word-fall-through, zero extra latency).
REQ-024 Beat transfers on axi_wvalid & axi_wready; pops FIFO; counter increments.
REQ-025 axi_wlast = axi_wvalid & (counter == axi_awlen); combinational from registered state.
REQ-026 Beat with wlast: DATA->DONE; DONE: wr_done=1 and wr_busy cleared for one cycle, then DONE->IDLE unconditionally.
REQ-027 Data push on wr_data_valid & wr_data_ready in any state, including before the command.
REQ-028 Simultaneous push and pop: both are performed; occupancy unchanged; at full, push is blocked because wr_data_ready is already low.
REQ-029 FIFO empty mid-burst: wvalid=0, counter holds, and no timeout applies.
REQ-030 axi_wready low while wvalid=1: wdata/wstrb/wlast held stable.
REQ-031 wr_req outside IDLE, or while init_done=0, is ignored.
REQ-032 init_done falling mid-burst: the current burst completes normally.
REQ-033 Counter width LEN_W; no wrap occurs within a burst because it terminates at awlen.

Reset
REQ-034 rstn=0 on any edge, including mid-burst: state IDLE, FIFO flushed, counter 0.
REQ-035 All outputs are 0 after reset: awaddr, awlen, awvalid, wvalid, wlast, wr_busy, wr_done.
REQ-036 After reset, wr_data_ready=1, and wr_ready follows init_done.

Structure
REQ-037 Shared package p_ddr holds the default DATA_W, ADDR_W, LEN_W, and FIFO_DEPTH constants and the state encoding.
REQ-038 Sub-module sync_fifo_fwft (WIDTH=DATA_W+STRB_W, DEPTH=FIFO_DEPTH) is the data buffer, with full, empty, and registered count.

Verification
REQ-039 Pre-fill 4 beats, then wr_req with addr=0x100, len=3, and awready/wready tied 1 -> awaddr=0x100, awlen=3, 4 beats in order, wlast on beat 4, wr_done 1 cycle later.
REQ-040 awready delayed 5 cycles -> awvalid held 6 cycles with stable addr, and no wvalid before the handshake.
REQ-041 Data trickled 1 beat per 3 cycles, len=15 -> wvalid gaps, 16 beats, and a single wlast on beat 16.
REQ-042 wready toggled randomly with wr_be=0x0000000F on beat 2 -> axi_wstrb=0x0000000F held through the stall.
REQ-043 FIFO filled to 16 -> wr_data_ready=0; simultaneous push and pop at 15 entries -> count stays 15.
REQ-044 rstn pulsed during beat 2 of 8 -> all outputs 0 next cycle, FIFO empty, and a new burst completes cleanly.
